dmem_access_ctrl: RTL and testbench

Data-memory access controller for the MEM stage of the pipeline. Sequences one load or store per instruction onto a ready/valid data-memory port, generating lane-replicated write data and byte enables. Returns sign- or zero-extended load data and holds the pipeline with `stall` until the access completes. Detects misaligned and illegal accesses, reports them, and does not issue them to memory.

---
 rtl/dmem_pkg.sv | 46 ++++
 rtl/dmem_access_ctrl_load_extend.sv | 26 ++
 rtl/dmem_access_ctrl.sv | 133 +++++++++++++
 tb/tb_dmem_access_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access controller.
// Holds the FSM encoding, funct3 codes and the lane/legality helpers.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } dmem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] encodes the access size for both signed and unsigned loads.
  function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = 4'b0011 << off;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] funct3, input logic [31:0] sd);
    case (funct3[1:0])
      2'b00:   store_wdata = {4{sd[7:0]}};
      2'b01:   store_wdata = {2{sd[15:0]}};
      default: store_wdata = sd;
    endcase
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_B:    is_legal = 1'b1;
      F3_H:    is_legal = ~off[0];
      F3_W:    is_legal = (off == 2'b00);
      F3_BU:   is_legal = ~we;
      F3_HU:   is_legal = ~we & ~off[0];
      default: is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_load_extend.sv
// Selects the addressed byte/half from a read word and sign- or zero-extends it.
module load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{off, 3'b000} +: 8];
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store sequencer onto a valid/ready data-memory port.
// Request stays stable from REQ entry until mem_req_ready is seen high on a rising edge.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              misaligned,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_rdata,
  output dmem_state_t       state_dbg
);

  dmem_state_t       state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       load_data_q, load_data_d;
  logic [31:0]       ext_data;
  logic              req_present;
  logic              req_legal;

  load_extend u_load_extend (
    .rdata     (mem_rsp_rdata),
    .funct3    (funct3_q),
    .off       (off_q),
    .load_data (ext_data)
  );

  // A simultaneous read and write request is treated as a store.
  assign req_present = MemWrite | MemRead;
  assign req_legal   = is_legal(MemWrite, funct3, addr[1:0]);

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    funct3_d      = funct3_q;
    off_d         = off_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    load_data_d   = load_data_q;
    stall         = 1'b0;
    misaligned    = 1'b0;
    mem_req_valid = 1'b0;
    load_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_present) begin
          if (req_legal) begin
            stall    = 1'b1;
            we_d     = MemWrite;
            funct3_d = funct3;
            off_d    = addr[1:0];
            addr_d   = {addr[ADDR_W-1:2], 2'b00};
            wdata_d  = store_wdata(funct3, store_data);
            be_d     = store_be(funct3, addr[1:0]);
            state_d  = REQ;
          end else begin
            misaligned = 1'b1;
          end
        end
      end
      REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_rsp_valid) begin
          load_data_d = ext_data;
          state_d     = DONE;
        end
      end
      DONE: begin
        // Pipeline inputs still hold the completing instruction here, so they are ignored.
        load_valid = ~we_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      be_q        <= 4'b0000;
      load_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      load_data_q <= load_data_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign load_data = load_data_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: table of single accesses plus multi-cycle sequences.
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite, MemRead;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, load_valid, misaligned;
  logic [31:0] load_data;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  dmem_state_t state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rdata;
    logic        exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_ld;
  } vec_t;

  vec_t vecs[17];

  dmem_access_ctrl #(.ADDR_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .MemWrite      (MemWrite),
    .MemRead       (MemRead),
    .funct3        (funct3),
    .addr          (addr),
    .store_data    (store_data),
    .stall         (stall),
    .load_data     (load_data),
    .load_valid    (load_valid),
    .misaligned    (misaligned),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .state_dbg     (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    MemWrite = 1'b0; MemRead = 1'b0; funct3 = 3'b000;
    addr = 32'd0; store_data = 32'd0;
  endtask

  function automatic vec_t mk(input logic wr, input logic rd, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                              input logic mis, input logic [3:0] be, input logic [31:0] wd,
                              input logic [31:0] ld);
    vec_t v;
    v.wr = wr; v.rd = rd; v.f3 = f3; v.a = a; v.sd = sd; v.rdata = rdata;
    v.exp_mis = mis; v.exp_be = be; v.exp_wdata = wd; v.exp_ld = ld;
    v.exp_addr = {a[31:2], 2'b00};
    return v;
  endfunction

  // Driver: one access with memory always ready and response one cycle after accept.
  task automatic do_access(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    MemWrite = v.wr; MemRead = v.rd; funct3 = v.f3; addr = v.a; store_data = v.sd;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
    #1;
    if (v.exp_mis) begin
      check({tag, " misaligned"}, misaligned, 1'b1);
      check({tag, " stall_low"}, stall, 1'b0);
      check({tag, " no_req"}, mem_req_valid, 1'b0);
      tick();
      check({tag, " stays_idle"}, state_dbg, IDLE);
      check({tag, " no_req_next"}, mem_req_valid, 1'b0);
      clear_inputs();
      return;
    end
    check({tag, " no_misaligned"}, misaligned, 1'b0);
    check({tag, " stall_idle"}, stall, 1'b1);
    tick(); #1;
    check({tag, " req_valid"}, mem_req_valid, 1'b1);
    check({tag, " mem_addr"}, mem_addr, v.exp_addr);
    check({tag, " mem_be"}, mem_be, v.exp_be);
    check({tag, " mem_we"}, mem_we, v.wr);
    check({tag, " stall_req"}, stall, 1'b1);
    if (v.wr) check({tag, " mem_wdata"}, mem_wdata, v.exp_wdata);
    tick();
    if (v.wr) begin
      #1;
      check({tag, " st_done"}, state_dbg, DONE);
      check({tag, " st_stall_done"}, stall, 1'b0);
      check({tag, " st_no_load_valid"}, load_valid, 1'b0);
    end else begin
      #1;
      check({tag, " ld_wait"}, state_dbg, WAIT);
      check({tag, " ld_stall_wait"}, stall, 1'b1);
      check({tag, " ld_req_dropped"}, mem_req_valid, 1'b0);
      mem_rsp_valid = 1'b1; mem_rsp_rdata = v.rdata;
      tick();
      mem_rsp_valid = 1'b0;
      #1;
      check({tag, " load_valid"}, load_valid, 1'b1);
      check({tag, " load_data"}, load_data, v.exp_ld);
      check({tag, " ld_stall_done"}, stall, 1'b0);
      check({tag, " ld_no_mis"}, misaligned, 1'b0);
    end
    tick();
    clear_inputs();
    #1;
    check({tag, " back_idle"}, state_dbg, IDLE);
    check({tag, " pulse_ended"}, load_valid, 1'b0);
  endtask

  initial begin
    vecs[0]  = mk(1, 0, F3_B,  32'h1003, 32'hAABBCCDD, 32'h0,        0, 4'b1000, 32'hDDDDDDDD, 32'h0);
    vecs[1]  = mk(1, 0, F3_H,  32'h2002, 32'h12345678, 32'h0,        0, 4'b1100, 32'h56785678, 32'h0);
    vecs[2]  = mk(1, 0, F3_W,  32'h300C, 32'hCAFEBABE, 32'h0,        0, 4'b1111, 32'hCAFEBABE, 32'h0);
    vecs[3]  = mk(0, 1, F3_BU, 32'h0001, 32'h0,        32'h0000F500, 0, 4'b0010, 32'h0,        32'h000000F5);
    vecs[4]  = mk(0, 1, F3_B,  32'h0001, 32'h0,        32'h0000F500, 0, 4'b0010, 32'h0,        32'hFFFFFFF5);
    vecs[5]  = mk(0, 1, F3_H,  32'h0006, 32'h0,        32'h80011234, 0, 4'b1100, 32'h0,        32'hFFFF8001);
    vecs[6]  = mk(0, 1, F3_HU, 32'h0004, 32'h0,        32'h80019234, 0, 4'b0011, 32'h0,        32'h00009234);
    vecs[7]  = mk(0, 1, F3_W,  32'h0008, 32'h0,        32'hDEADBEEF, 0, 4'b1111, 32'h0,        32'hDEADBEEF);
    vecs[8]  = mk(0, 1, F3_B,  32'h0003, 32'h0,        32'h7F000000, 0, 4'b1000, 32'h0,        32'h0000007F);
    vecs[9]  = mk(1, 0, F3_W,  32'h0006, 32'h11223344, 32'h0,        1, 4'b0000, 32'h0,        32'h0);
    vecs[10] = mk(1, 0, F3_H,  32'h0001, 32'h11223344, 32'h0,        1, 4'b0000, 32'h0,        32'h0);
    vecs[11] = mk(0, 1, F3_H,  32'h0003, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        32'h0);
    vecs[12] = mk(1, 0, F3_BU, 32'h0000, 32'h11223344, 32'h0,        1, 4'b0000, 32'h0,        32'h0);
    vecs[13] = mk(0, 1, 3'b011, 32'h0000, 32'h0,       32'h0,        1, 4'b0000, 32'h0,        32'h0);
    vecs[14] = mk(0, 1, F3_W,  32'h0002, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        32'h0);
    vecs[15] = mk(1, 1, F3_BU, 32'h0000, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        32'h0);
    vecs[16] = mk(1, 1, F3_B,  32'h0005, 32'h00000011, 32'h0,        0, 4'b0010, 32'h11111111, 32'h0);

    reset = 1'b1;
    clear_inputs();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst state", state_dbg, IDLE);
    check("rst stall", stall, 1'b0);
    check("rst req_valid", mem_req_valid, 1'b0);
    check("rst mem_we", mem_we, 1'b0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst mem_be", mem_be, 4'b0000);
    check("rst load_data", load_data, 32'd0);
    check("rst load_valid", load_valid, 1'b0);
    check("rst misaligned", misaligned, 1'b0);

    tick();
    for (int i = 0; i < 17; i++) begin
      do_access(i, vecs[i]);
    end

    // LH with ready held low for 3 REQ cycles: request must stay stable.
    MemRead = 1'b1; funct3 = F3_H; addr = 32'h2002; mem_req_ready = 1'b0;
    #1;
    check("lh stall_idle", stall, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 1) mem_rsp_valid = 1'b1;
      #1;
      check("lh hold req_valid", mem_req_valid, 1'b1);
      check("lh hold addr", mem_addr, 32'h2000);
      check("lh hold be", mem_be, 4'b1100);
      check("lh hold we", mem_we, 1'b0);
      check("lh hold stall", stall, 1'b1);
      mem_rsp_valid = 1'b0;
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #1;
    check("lh wait", state_dbg, WAIT);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h80011234;
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    check("lh load_valid", load_valid, 1'b1);
    check("lh load_data", load_data, 32'hFFFF8001);
    check("lh stall_done", stall, 1'b0);
    tick();
    clear_inputs();
    #1;
    check("lh idle", state_dbg, IDLE);

    // Reset while a load is in WAIT, then a stale response arrives.
    MemRead = 1'b1; funct3 = F3_W; addr = 32'h0010; mem_req_ready = 1'b1;
    tick();
    tick();
    #1;
    check("rw wait", state_dbg, WAIT);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_inputs();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h12345678;
    #1;
    check("rw state", state_dbg, IDLE);
    check("rw req_valid", mem_req_valid, 1'b0);
    check("rw mem_addr", mem_addr, 32'd0);
    check("rw mem_be", mem_be, 4'b0000);
    check("rw load_valid", load_valid, 1'b0);
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    check("rw stale state", state_dbg, IDLE);
    check("rw stale load_valid", load_valid, 1'b0);
    check("rw stale load_data", load_data, 32'd0);
    check("rw stale stall", stall, 1'b0);

    // Back-to-back SW then LW with memory always ready.
    MemWrite = 1'b1; funct3 = F3_W; addr = 32'h0040; store_data = 32'h01020304;
    mem_req_ready = 1'b1;
    tick(); #1;
    check("bb sw req", mem_req_valid, 1'b1);
    check("bb sw we", mem_we, 1'b1);
    tick(); #1;
    check("bb sw done", state_dbg, DONE);
    check("bb sw done no_req", mem_req_valid, 1'b0);
    tick();
    MemWrite = 1'b0; MemRead = 1'b1; funct3 = F3_W; addr = 32'h0044;
    #1;
    check("bb lw idle no_req", mem_req_valid, 1'b0);
    check("bb lw idle stall", stall, 1'b1);
    tick(); #1;
    check("bb lw req", mem_req_valid, 1'b1);
    check("bb lw we", mem_we, 1'b0);
    check("bb lw addr", mem_addr, 32'h0044);
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hA5A55A5A;
    #1;
    check("bb lw wait no_req", mem_req_valid, 1'b0);
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    check("bb lw load_valid", load_valid, 1'b1);
    check("bb lw load_data", load_data, 32'hA5A55A5A);
    tick();
    clear_inputs();
    #1;
    check("bb idle", state_dbg, IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // misaligned and load_valid must never overlap.
  always @(negedge clk) begin
    if (!reset && misaligned && load_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL overlap: misaligned=%0b load_valid=%0b required not both high", misaligned, load_valid);
    end
  end

endmodule
